// File: rtl/vmx_pkg.sv
// vmx_pkg: shared constants and FSM encodings for the vmx blocks.
// Optional ReLU stage is controlled by macro VMX_RQ_RELU_EN.
package vmx_pkg;

  localparam int LANES_D = 4;
  localparam int ACC_W_D = 32;
  localparam int OUT_W_D = 16;

  localparam int INT16_MAX = 32767;
  localparam int INT16_MIN = -32768;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/vmx_rq_lane.sv
// vmx_rq_lane: one lane of round/shift, bias, optional ReLU, int16 sat.
// ReLU logic exists only when VMX_RQ_RELU_EN is defined.
module vmx_rq_lane
  import vmx_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vld,
  input  logic [ACC_W-1:0] acc,
  input  logic [4:0]       shift,
  input  logic [OUT_W-1:0] bias,
  input  logic             relu,
  output logic             a_vld,
  output logic             o_vld,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat
);

  localparam int AW = ACC_W + 1;
  localparam int UW = ACC_W + 2;

  localparam logic signed [UW-1:0] U_MAX = UW'(INT16_MAX);
  localparam logic signed [UW-1:0] U_MIN = UW'(INT16_MIN);

  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] r;
  logic signed [AW-1:0] t;
  logic signed [AW-1:0] t_q;
  logic        [5:0]    sidx;

  logic signed [UW-1:0] b_ext;
  logic signed [UW-1:0] u;
  logic        [OUT_W-1:0] s_val;
  logic                 s_hit;

`ifndef VMX_RQ_RELU_EN
  logic unused_relu;
  assign unused_relu = relu;
`endif

  // Stage A math: add half an LSB of the shift, then arithmetic shift.
  always_comb begin
    rnd  = '0;
    sidx = {1'b0, shift} - 6'd1;
    if (shift != 5'd0)
      rnd[sidx] = 1'b1;
    r = $signed({acc[ACC_W-1], acc}) + rnd;
    t = r >>> shift;
  end

  // Stage B math: bias, optional ReLU, clamp to the int16 range.
  always_comb begin
    b_ext = {{(UW-OUT_W){bias[OUT_W-1]}}, bias};
    u     = $signed({t_q[AW-1], t_q}) + b_ext;
`ifdef VMX_RQ_RELU_EN
    if (relu && u[UW-1])
      u = '0;
`endif
    s_hit = 1'b0;
    s_val = u[OUT_W-1:0];
    if (u > U_MAX) begin
      s_val = OUT_W'(INT16_MAX);
      s_hit = 1'b1;
    end else if (u < U_MIN) begin
      s_val = OUT_W'(INT16_MIN);
      s_hit = 1'b1;
    end
  end

  // Stage A register: shifted value and its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld <= 1'b0;
      t_q   <= '0;
    end else if (clr) begin
      a_vld <= 1'b0;
    end else begin
      a_vld <= vld;
      if (vld)
        t_q <= t;
    end
  end

  // Stage B register: saturated activation, clamp flag and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld  <= 1'b0;
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (clr) begin
      o_vld <= 1'b0;
    end else begin
      o_vld <= a_vld;
      if (a_vld) begin
        o_data <= s_val;
        o_sat  <= s_hit;
      end
    end
  end

endmodule

// File: rtl/vmx_requant_writer.sv
// vmx_requant_writer: walks result rows, requantises, writes int16 rows.
// Optional ReLU stage is controlled by macro VMX_RQ_RELU_EN.
module vmx_requant_writer
  import vmx_pkg::*;
#(
  parameter int LANES  = LANES_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      src_base,
  input  logic [ADDR_W-1:0]      dst_base,
  input  logic [ADDR_W-1:0]      row_cnt,
  input  logic [4:0]             shift,
  input  logic [LANES*OUT_W-1:0] bias,
  input  logic                   relu_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_en,
  input  logic [LANES*ACC_W-1:0] rd_data,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   wr_en,
  output logic [LANES*OUT_W-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            flag
);

  state_t state;

  logic [ADDR_W-1:0]      src_q;
  logic [ADDR_W-1:0]      dst_q;
  logic [ADDR_W-1:0]      rows_q;
  logic [ADDR_W-1:0]      rd_cnt;
  logic [ADDR_W-1:0]      wr_cnt;
  logic [4:0]             shift_q;
  logic [LANES*OUT_W-1:0] bias_q;
  logic [RD_LAT-1:0]      rd_vld;
  logic                   sat_sticky;
  logic                   relu_q;

  logic [LANES-1:0] lane_a;
  logic [LANES-1:0] lane_o;
  logic [LANES-1:0] lane_sat;
  logic             a_vld;
  logic             accept;

  assign accept = start && !abort && (state == S_IDLE);
  assign a_vld  = &lane_a;
  assign wr_en  = &lane_o;
  assign flag   = {27'b0, sat_sticky, state, busy};

`ifdef VMX_RQ_RELU_EN
  // ReLU enable captured with the rest of the job parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      relu_q <= 1'b0;
    else if (accept)
      relu_q <= relu_en;
  end
`else
  logic unused_relu_en;
  assign unused_relu_en = relu_en;
  assign relu_q = 1'b0;
`endif

  // Job control FSM with registered read strobe, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_cnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rows_q  <= '0;
      shift_q <= '0;
      bias_q  <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      rd_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            rows_q  <= row_cnt;
            shift_q <= shift;
            bias_q  <= bias;
            if (row_cnt != '0) begin
              state   <= S_ISSUE;
              rd_en   <= 1'b1;
              rd_addr <= src_base;
              rd_cnt  <= {{(ADDR_W-1){1'b0}}, 1'b1};
              busy    <= 1'b1;
            end else begin
              state  <= S_DONE;
              rd_cnt <= '0;
              done   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (rd_cnt == rows_q) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= src_q + rd_cnt;
            rd_cnt  <= rd_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // Only the output stage may still hold data: it writes now.
          if (!(|rd_vld) && !a_vld) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Read-data valid tracks rd_en through the BRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_vld <= '0;
    else if (abort)
      rd_vld <= '0;
    else
      rd_vld <= RD_LAT'({rd_vld, rd_en});
  end

  // Write address follows stage A so it lands with the lane data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_cnt  <= '0;
    end else if (accept) begin
      wr_cnt <= '0;
    end else if (a_vld && !abort) begin
      wr_addr <= dst_q + wr_cnt;
      wr_cnt  <= wr_cnt + 1'b1;
    end
  end

  // Sticky saturation flag: cleared by a new job, kept across abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_sticky <= 1'b0;
    else if (accept)
      sat_sticky <= 1'b0;
    else if (wr_en && (|lane_sat))
      sat_sticky <= 1'b1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vmx_rq_lane #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort),
      .vld   (rd_vld[RD_LAT-1]),
      .acc   (rd_data[k*ACC_W +: ACC_W]),
      .shift (shift_q),
      .bias  (bias_q[k*OUT_W +: OUT_W]),
      .relu  (relu_q),
      .a_vld (lane_a[k]),
      .o_vld (lane_o[k]),
      .o_data(wr_data[k*OUT_W +: OUT_W]),
      .o_sat (lane_sat[k])
    );
  end

endmodule

// File: tb/tb_vmx_requant_writer.sv
// tb_vmx_requant_writer: directed bench for vmx_requant_writer.
// ReLU expectations follow macro VMX_RQ_RELU_EN.
module tb_vmx_requant_writer;
  import vmx_pkg::*;

  localparam int RD_LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         relu_en = 1'b0;
  logic [7:0]   src_base = '0;
  logic [7:0]   dst_base = '0;
  logic [7:0]   row_cnt = '0;
  logic [4:0]   shift = '0;
  logic [63:0]  bias = '0;
  logic [7:0]   rd_addr;
  logic [7:0]   wr_addr;
  logic         rd_en;
  logic         wr_en;
  logic [127:0] rd_data;
  logic [63:0]  wr_data;
  logic         busy;
  logic         done;
  logic [31:0]  flag;

  logic [127:0] mem [256];

  int errs = 0;
  int total = 0;
  int cyc = 0;
  int st_cyc = 0;
  int wb, rb, db;

  logic [7:0]  rdq [$];
  int          rdc [$];
  logic [7:0]  waq [$];
  logic [63:0] wdq [$];
  int          wcq [$];
  int          dcq [$];

  vmx_requant_writer #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .row_cnt(row_cnt),
    .shift(shift), .bias(bias), .relu_en(relu_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .flag(flag)
  );

  always #5 clk = ~clk;

  // BRAM model plus a log of every strobe, stamped by cycle.
  always @(posedge clk) begin
    if (rd_en) begin
      rdq.push_back(rd_addr);
      rdc.push_back(cyc);
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      waq.push_back(wr_addr);
      wdq.push_back(wr_data);
      wcq.push_back(cyc);
    end
    if (done) dcq.push_back(cyc);
    if (start) st_cyc = cyc;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] s, input logic [7:0] d,
                    input logic [7:0] n, input logic [4:0] sh,
                    input logic [63:0] b, input logic re);
    wb = waq.size();
    rb = rdq.size();
    db = dcq.size();
    src_base = s;
    dst_base = d;
    row_cnt  = n;
    shift    = sh;
    bias     = b;
    relu_en  = re;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (dcq.size() == db && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", 64'(dcq.size() - db), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_relu;
    rd_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flag", 64'(flag), 64'd0);
    chk("rst_strobes", 64'({rd_en, wr_en, busy, done}), 64'd0);
    chk("rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    chk("rst_wdata", wr_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      mem[8'h10 + i] = {32'hFFFF63C0, 32'd300, 32'hFFFFFFFE, 32'(i + 1)};
    go(8'h10, 8'h40, 8'd4, 5'd0, 64'h0, 1'b0);
    chk("basic_busy", 64'(flag), 64'h3);
    wait_done();
    chk("basic_nwr", 64'(waq.size() - wb), 64'd4);
    if (waq.size() - wb == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_addr", 64'(waq[wb + i]), 64'(8'h40 + i));
        chk("basic_data", wdq[wb + i],
            {16'h8000, 16'h012C, 16'hFFFE, 16'(i + 1)});
      end
      chk("basic_lat", 64'(wcq[wb] - rdc[rb]), 64'(RD_LAT + 2));
      chk("basic_done_t", 64'(dcq[db] - wcq[wb + 3]), 64'd1);
    end
    chk("basic_flag", 64'(flag), 64'h10);

    mem[8'h20] = {32'h7FFFFFFF, 32'h0, 32'hFFFFFF80, 32'h180};
    mem[8'h21] = {32'h100, 32'hFFFFFE80, 32'hFFFFFF7F, 32'h17F};
    go(8'h20, 8'h50, 8'd2, 5'd8, {16'h0, 16'hFFFD, 16'h0, 16'h5}, 1'b0);
    wait_done();
    chk("rnd_nwr", 64'(waq.size() - wb), 64'd2);
    if (waq.size() - wb == 2) begin
      chk("rnd_row0", wdq[wb], {16'h7FFF, 16'hFFFD, 16'h0000, 16'h0007});
      chk("rnd_row1", wdq[wb + 1], {16'h0001, 16'hFFFC, 16'hFFFF, 16'h0006});
      chk("rnd_addr1", 64'(waq[wb + 1]), 64'h51);
    end
    chk("rnd_flag", 64'(flag), 64'h10);

    mem[8'h30] = {32'd0, 32'hFFFFFFFF, 32'd50, 32'hFFFFFF9C};
`ifdef VMX_RQ_RELU_EN
    exp_relu = {16'h0000, 16'h0000, 16'h0032, 16'h0000};
`else
    exp_relu = {16'h0000, 16'hFFFF, 16'h0032, 16'hFF9C};
`endif
    go(8'h30, 8'h60, 8'd1, 5'd0, 64'h0, 1'b1);
    wait_done();
    chk("relu_on_nwr", 64'(waq.size() - wb), 64'd1);
    if (waq.size() - wb == 1) chk("relu_on", wdq[wb], exp_relu);
    chk("relu_flag", 64'(flag), 64'h0);
    go(8'h30, 8'h60, 8'd1, 5'd0, 64'h0, 1'b0);
    wait_done();
    chk("relu_off_nwr", 64'(waq.size() - wb), 64'd1);
    if (waq.size() - wb == 1)
      chk("relu_off", wdq[wb], {16'h0000, 16'hFFFF, 16'h0032, 16'hFF9C});

    mem[8'hFE] = 128'd11;
    mem[8'hFF] = 128'd22;
    mem[8'h00] = 128'd33;
    go(8'hFE, 8'hFF, 8'd3, 5'd0, 64'h0, 1'b0);
    wait_done();
    chk("wrap_nrd", 64'(rdq.size() - rb), 64'd3);
    chk("wrap_nwr", 64'(waq.size() - wb), 64'd3);
    if (rdq.size() - rb == 3 && waq.size() - wb == 3) begin
      chk("wrap_rd", 64'({rdq[rb], rdq[rb + 1], rdq[rb + 2]}), 64'hFEFF00);
      chk("wrap_wr", 64'({waq[wb], waq[wb + 1], waq[wb + 2]}), 64'hFF0001);
      chk("wrap_d0", wdq[wb], 64'd11);
      chk("wrap_d2", wdq[wb + 2], 64'd33);
    end

    go(8'h10, 8'h40, 8'd0, 5'd0, 64'h0, 1'b0);
    wait_done();
    chk("zero_nrd", 64'(rdq.size() - rb), 64'd0);
    chk("zero_nwr", 64'(waq.size() - wb), 64'd0);
    if (dcq.size() > db) chk("zero_done_t", 64'(dcq[db] - st_cyc), 64'd1);

    for (int i = 0; i < 8; i++) mem[8'h80 + i] = 128'(i + 1);
    go(8'h80, 8'h90, 8'd8, 5'd0, 64'h0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_flag", 64'(flag), 64'h0);
    chk("abort_strobes", 64'({rd_en, wr_en, done}), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nwr", 64'(waq.size() - wb), 64'd0);
    chk("abort_ndone", 64'(dcq.size() - db), 64'd0);
    go(8'h80, 8'h90, 8'd2, 5'd0, 64'h0, 1'b0);
    wait_done();
    chk("restart_nwr", 64'(waq.size() - wb), 64'd2);
    if (waq.size() - wb == 2) begin
      chk("restart_d1", wdq[wb + 1], 64'd2);
      chk("restart_a1", 64'(waq[wb + 1]), 64'h91);
    end

    go(8'h80, 8'hA0, 8'd4, 5'd0, 64'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_state", 64'(flag[3:1]), 64'(S_DRAIN));
    src_base = 8'h10;
    row_cnt  = 8'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("busy_ndone", 64'(dcq.size() - db), 64'd1);
    chk("busy_nwr", 64'(waq.size() - wb), 64'd4);
    chk("busy_nrd", 64'(rdq.size() - rb), 64'd4);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule

// File: doc/vmx_requant_writer.md
Name: vmx_requant_writer

Overview:
- Downstream stage of the systolic-array wrapper. Walks the 128-bit result rows the wrapper exported to result BRAM (4 lanes x 32-bit accumulators).
- Per lane: rounds, arithmetic-shifts, adds a bias, optionally applies ReLU, saturates to int16.
- Packs each row into a 64-bit word and writes it to the activation BRAM. That word width matches the array's 64-bit input port, so the next layer can consume it directly.

Parameters:
- LANES, 4, accumulator lanes per row (equals the array PE_SIZE).
- ACC_W, 32, accumulator width per lane (2 x PORT_WIDTH).
- OUT_W, 16, output activation width per lane.
- ADDR_W, 8, BRAM address width.
- RD_LAT, 1, result BRAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begins a job when IDLE
- abort  in  1  synchronous soft clear; returns to IDLE
- src_base  in  ADDR_W  first result-BRAM row
- dst_base  in  ADDR_W  first activation-BRAM row
- row_cnt  in  ADDR_W  rows to process (0 allowed)
- shift  in  5  right-shift amount, 0..31
- bias  in  LANES*OUT_W  per-lane signed bias; lane k at [k*OUT_W +: OUT_W]
- relu_en  in  1  ReLU enable (see Optional Feature)
- rd_addr  out  ADDR_W  result BRAM read address
- rd_en  out  1  read strobe
- rd_data  in  LANES*ACC_W  result BRAM read data
- wr_addr  out  ADDR_W  activation BRAM write address
- wr_en  out  1  write strobe
- wr_data  out  LANES*OUT_W  packed int16 lanes
- busy  out  1  high from the accepted start until the last write completes
- done  out  1  1-cycle pulse at job end
- flag  out  32  {27'b0, sat_sticky, state[2:0], busy}

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pipeline valids 0, sat_sticky 0.
- Inputs are latched at start: src_base, dst_base, row_cnt, shift, bias, relu_en. Changes during a job have no effect.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on start with row_cnt != 0.
  - IDLE -> DONE on start with row_cnt == 0.
  - ISSUE: rd_en=1, rd_addr = src_base + rd_cnt (mod 2^ADDR_W), one row per cycle. After row_cnt issues -> DRAIN.
  - DRAIN: waits until all pipeline valids are 0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start while busy is ignored.
- Pipeline, from rd_en to wr_en: RD_LAT + 2 cycles.
  - Stage A, per lane, intermediate width ACC_W+1:
    - r = acc + (shift != 0 ? 1 << (shift-1) : 0)
    - t = r >>> shift
  - Stage B:
    - u = t + sign_extend(bias_k)
    - if ReLU is active and u < 0: u = 0
    - saturate to [-32768, 32767]
    - any clamp sets sat_sticky
    - wr_addr = dst_base + wr_cnt (mod 2^ADDR_W); wr_en=1
- Throughput: 1 row/cycle. Writes are strictly in row order, no gaps.
- Address wrap past 2^ADDR_W-1 to 0 is legal and silent.
- abort:
  - Highest priority over start in the same cycle.
  - Next cycle: state IDLE, all valids cleared, no further wr_en, busy=0.
  - No done pulse.
  - sat_sticky is preserved. It clears only on reset or an accepted start.
- rst_n deassertion mid-job: as reset; no partial writes resume.

Optional Feature:
- Macro VMX_RQ_RELU_EN.
- Defined: the ReLU step is built; relu_en (latched at start) gates it.
- Undefined: no ReLU logic; relu_en is ignored; negative values pass to saturation unchanged.

Decomposition:
- Package vmx_pkg holds:
  - FSM state encodings (3-bit), shared with the wrapper's state encodings reported in flag
  - LANES/ACC_W/OUT_W defaults
  - INT16_MAX / INT16_MIN constants
- One sub-module, vmx_rq_lane: a single lane's round / shift / bias / ReLU / saturate, two registered stages with a valid input. Instantiated LANES times in a generate loop.
- Top level: FSM, counters, address generation, lane packing.

Test Plan:
- Basic, no shift: src_base=0x10, dst_base=0x40, row_cnt=4, shift=0, bias=0; lane values 1,-2,300,-40000. Expected: writes to 0x40..0x43 starting RD_LAT+2 cycles after the first rd_en; lanes 1, -2, 300, -32768; sat_sticky=1; done one cycle after the last write.
- Rounding shift plus bias: acc=0x0000_0180, shift=8, bias=5 -> 2+5=7. acc=0xFFFF_FF80, shift=8 -> 0 (round half up).
- ReLU with VMX_RQ_RELU_EN defined: relu_en=1, acc=-100, shift=0 -> 0; relu_en=0 -> -100. With the macro undefined, relu_en=1 still gives -100.
- Wrap and boundaries: src_base=0xFE, dst_base=0xFF, row_cnt=3 -> reads 0xFE,0xFF,0x00 and writes 0xFF,0x00,0x01. row_cnt=0 -> no rd_en/wr_en, done the cycle after IDLE.
- Abort: abort asserted on the 2nd ISSUE cycle of a row_cnt=8 job -> at most RD_LAT+1 further writes never occur; wr_en=0 from the next cycle; no done; busy=0. A new start then runs normally.
- Start while busy: a second start during DRAIN is ignored; exactly one done pulse.
